// File: rtl/instr_fetch_unit.sv
// Multicycle fetch datapath: PC, instruction register, MDR and field decode.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        PCSrc,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        Zero,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic [31:0] ReadData,
  input  logic        mem_rdy,
  output logic [31:0] MemAddr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [15:0] Imm,
  output logic [31:0] Data,
  output logic        stall,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  logic        pc_en;
  logic        ir_en;
  logic [31:0] pc_nxt;

  assign stall   = IRWrite & ~mem_rdy;
  assign pc_en   = (PCWrite | (Branch & Zero)) & ~stall;
  assign ir_en   = IRWrite & mem_rdy;
  assign pc_nxt  = PCSrc ? {ALUOut[31:2], 2'b00}
                         : {ALUResult[31:2], 2'b00};
  assign MemAddr = IorD ? ALUOut : PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC    <= RESET_PC;
      Instr <= '0;
      Data  <= '0;
    end else begin
      if (pc_en)   PC    <= pc_nxt;
      if (ir_en)   Instr <= ReadData;
      if (mem_rdy) Data  <= ReadData;
    end
  end

  assign Opcode = Instr[31:26];
  assign Rs     = Instr[25:21];
  assign Rt     = Instr[20:16];
  assign Rd     = Instr[15:11];
  assign Imm    = Instr[15:0];
  assign Funct  = Instr[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] ret_q;
  logic [31:0] stl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
      stl_q <= '0;
    end else begin
      if (ir_en) ret_q <= ret_q + 32'd1;
      if (stall) stl_q <= stl_q + 32'd1;
    end
  end

  assign retired_cnt = ret_q;
  assign stall_cnt   = stl_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle model plus directed literal checks.
// Counter expectations follow FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, Branch, PCSrc, IorD, IRWrite, Zero;
  logic [31:0] ALUResult, ALUOut, ReadData;
  logic        mem_rdy;
  logic [31:0] MemAddr, PC, Instr, Data;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  Rs, Rt, Rd;
  logic [15:0] Imm;
  logic        stall;
  logic [31:0] retired_cnt, stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
    .IorD(IorD), .IRWrite(IRWrite), .Zero(Zero),
    .ALUResult(ALUResult), .ALUOut(ALUOut),
    .ReadData(ReadData), .mem_rdy(mem_rdy),
    .MemAddr(MemAddr), .PC(PC), .Instr(Instr),
    .Opcode(Opcode), .Funct(Funct),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm),
    .Data(Data), .stall(stall),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Architectural model: what each register must hold after each edge.
  logic [31:0] m_pc, m_ir, m_dr, m_ret, m_stl;
  logic        m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc  = RPC;
      m_ir  = 32'd0;
      m_dr  = 32'd0;
      m_ret = 32'd0;
      m_stl = 32'd0;
    end else begin
      m_wait = IRWrite && !mem_rdy;
      if (!m_wait && (PCWrite || (Branch && Zero))) begin
        if (PCSrc) m_pc = ALUOut / 4 * 4;
        else       m_pc = ALUResult / 4 * 4;
      end
      if (IRWrite && mem_rdy) begin
        m_ir  = ReadData;
        m_ret = m_ret + 1;
      end
      if (mem_rdy) m_dr = ReadData;
      if (m_wait) m_stl = m_stl + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  always @(negedge clk) begin
    chk("m_pc", PC, m_pc);
    chk("m_instr", Instr, m_ir);
    chk("m_data", Data, m_dr);
    chk("m_addr", MemAddr, IorD ? ALUOut : m_pc);
    chk("m_stall", {31'd0, stall}, {31'd0, IRWrite & ~mem_rdy});
    chk("m_fields", {Opcode, Rs, Rt, Rd, Funct},
        {m_ir[31:26], m_ir[25:11], m_ir[5:0]});
    chk("m_imm", {16'd0, Imm}, {16'd0, m_ir[15:0]});
    chk("m_ret", retired_cnt, cnt_exp(m_ret));
    chk("m_stl", stall_cnt, cnt_exp(m_stl));
  end

  task automatic drv(input logic pcw, input logic br, input logic src,
                     input logic iord, input logic irw, input logic z,
                     input logic [31:0] alur, input logic [31:0] aluo,
                     input logic [31:0] rd, input logic rdy);
    PCWrite = pcw; Branch = br; PCSrc = src; IorD = iord;
    IRWrite = irw; Zero = z; ALUResult = alur; ALUOut = aluo;
    ReadData = rd; mem_rdy = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drv(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #17 rst_n = 1'b1;
    #1;
    chk("rst_pc", PC, 32'h0040_0000);
    chk("rst_addr", MemAddr, 32'h0040_0000);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_data", Data, 32'h0);
    tick();

    // fetch with same-cycle PC update
    drv(1, 0, 0, 0, 1, 0, 32'h0040_0004, 32'h0, 32'h2008_0005, 1);
    tick();
    chk("f_instr", Instr, 32'h2008_0005);
    chk("f_op", {26'd0, Opcode}, 32'h08);
    chk("f_rt", {27'd0, Rt}, 32'd8);
    chk("f_imm", {16'd0, Imm}, 32'h5);
    chk("f_pc", PC, 32'h0040_0004);
    idle();
    tick();

    // stalled fetch after a fresh reset
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drv(1, 0, 0, 0, 1, 0, 32'h0040_0004, 32'h0, 32'h2008_0005, 0);
    #1 chk("s_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_pc_hold", PC, 32'h0040_0000);
      chk("s_ir_hold", Instr, 32'h0);
    end
    mem_rdy = 1'b1;
    tick();
    chk("s_pc", PC, 32'h0040_0004);
    chk("s_instr", Instr, 32'h2008_0005);
    chk("s_ret", retired_cnt, cnt_exp(32'd1));
    chk("s_stl", stall_cnt, cnt_exp(32'd3));
    idle();
    tick();

    // branch taken / not taken / PCSrc not overridden
    drv(0, 1, 1, 0, 0, 1, 32'h0, 32'h0040_0020, 32'h0, 0);
    tick();
    chk("b_taken", PC, 32'h0040_0020);
    drv(0, 1, 1, 0, 0, 0, 32'h0, 32'h0040_0040, 32'h0, 0);
    tick();
    chk("b_not", PC, 32'h0040_0020);
    drv(0, 1, 0, 0, 0, 1, 32'h0040_0024, 32'h0040_0080, 32'h0, 0);
    tick();
    chk("b_src0", PC, 32'h0040_0024);

    // data access
    drv(0, 0, 0, 1, 0, 0, 32'h0, 32'h1001_0000, 32'hDEAD_BEEF, 1);
    #1 chk("d_addr", MemAddr, 32'h1001_0000);
    tick();
    chk("d_data", Data, 32'hDEAD_BEEF);
    chk("d_instr", Instr, 32'h2008_0005);

    // stall blocks PCWrite and Branch
    drv(1, 1, 1, 0, 1, 1, 32'h0, 32'h0000_1000, 32'h1111_1111, 0);
    tick();
    chk("st_pc", PC, 32'h0040_0024);
    chk("st_data", Data, 32'hDEAD_BEEF);

    // low bits forced, wrap
    drv(1, 0, 0, 0, 0, 0, 32'h0040_0007, 32'h0, 32'h0, 0);
    tick();
    chk("al_pc", PC, 32'h0040_0004);
    ALUResult = 32'hFFFF_FFFC;
    tick();
    chk("w_top", PC, 32'hFFFF_FFFC);
    ALUResult = 32'hFFFF_FFFC + 32'd4;
    tick();
    chk("w_zero", PC, 32'h0);

    // reset in the middle of a stall
    drv(1, 0, 0, 0, 1, 0, 32'h0000_0040, 32'h0, 32'h0, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("r_pc", PC, RPC);
    chk("r_instr", Instr, 32'h0);
    chk("r_ret", retired_cnt, 32'h0);
    chk("r_stl", stall_cnt, 32'h0);
    chk("r_stall", {31'd0, stall}, 32'd1);
    IRWrite = 1'b0;
    #1 chk("r_stall0", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    idle();
    #1 chk("r_addr", MemAddr, RPC);
    tick();
    chk("r_pc2", PC, RPC);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
